shift_feeder: RTL and testbench

Upstream byte sequencer for the 8-bit right-shift register (`shift_reg`). It buffers bytes written by a producer in a small FIFO. For each byte it drives `d_in` and a one-cycle `load` pulse. It then holds `load` low for exactly WIDTH cycles so the byte shifts fully out before the next byte is loaded. Its `d_in`/`load` outputs connect directly to the shift register's `d_in`/`load` inputs, and both blocks share `clock` and `reset`.

---
 rtl/shift_feeder_if.sv | 26 ++
 rtl/shift_feeder.sv | 137 +++++++++++++
 tb/tb_shift_feeder.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/shift_feeder_if.sv
// Producer-side and shift-register-side signals of the byte feeder.
// The slave modport is the feeder's view; master is the view of whatever drives it.
interface shift_feeder_if #(
   parameter int WIDTH = 8,
   parameter int AW    = 2
);
   logic             wr_en;
   logic [WIDTH-1:0] wr_data;
   logic             flush;
   logic             full;
   logic [AW:0]      count;
   logic             overflow;
   logic             busy;
   logic             load;
   logic [WIDTH-1:0] d_in;

   modport slave (
      input  wr_en, wr_data, flush,
      output full, count, overflow, busy, load, d_in
   );

   modport master (
      output wr_en, wr_data, flush,
      input  full, count, overflow, busy, load, d_in
   );
endinterface

// File: rtl/shift_feeder.sv
// Small FIFO plus a load/shift sequencer that paces bytes into an external right-shift register.
// Each byte gets one load cycle followed by exactly WIDTH shift cycles.
module shift_feeder #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input logic           clock,
   input logic           reset,
   shift_feeder_if.slave bus
);
   localparam int             CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);
   localparam logic [AW:0]    CNT_FULL = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_e;

   state_e                      state_q, state_d;
   logic [CW-1:0]               cnt_q, cnt_d;
   logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
   logic [AW-1:0]               wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]               rd_ptr_q, rd_ptr_d;
   logic [AW:0]                 count_q, count_d;
   logic                        full_q, full_d;
   logic                        overflow_q, overflow_d;
   logic                        busy_q, busy_d;
   logic                        load_q, load_d;
   logic [WIDTH-1:0]            d_in_q, d_in_d;
   logic                        push, pop;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         mem_q      <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         full_q     <= 1'b0;
         overflow_q <= 1'b0;
         busy_q     <= 1'b0;
         load_q     <= 1'b0;
         d_in_q     <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         mem_q      <= mem_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         full_q     <= full_d;
         overflow_q <= overflow_d;
         busy_q     <= busy_d;
         load_q     <= load_d;
         d_in_q     <= d_in_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      mem_d      = mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      d_in_d     = d_in_q;
      pop        = 1'b0;

      // Pop decisions look at the registered count, so a write landing on the
      // last shift cycle is picked up one cycle later through IDLE.
      unique case (state_q)
         IDLE: begin
            if (count_q != '0) begin
               pop     = 1'b1;
               state_d = LOAD;
            end
         end
         LOAD: begin
            state_d = SHIFT;
            cnt_d   = '0;
         end
         SHIFT: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d = '0;
               if (count_q != '0) begin
                  pop     = 1'b1;
                  state_d = LOAD;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      push = bus.wr_en && !full_q && !bus.flush;
      if (!bus.flush)
         overflow_d = overflow_q | (bus.wr_en & full_q);

      if (bus.flush) begin
         pop      = 1'b0;
         state_d  = IDLE;
         cnt_d    = '0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (pop) begin
            d_in_d   = mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         if (push) begin
            mem_d[wr_ptr_q] = bus.wr_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
         end
         unique case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
         endcase
      end

      full_d = (count_d == CNT_FULL);
      load_d = (state_d == LOAD);
      busy_d = (state_d != IDLE);
   end

   assign bus.full     = full_q;
   assign bus.count    = count_q;
   assign bus.overflow = overflow_q;
   assign bus.busy     = busy_q;
   assign bus.load     = load_q;
   assign bus.d_in     = d_in_q;
endmodule

// File: tb/tb_shift_feeder.sv
// Directed bench for shift_feeder with a chained right-shift register model.
module tb_shift_feeder;
   logic clock = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;
   logic [7:0] sr;

   shift_feeder_if #(.WIDTH(8), .AW(2)) bus ();

   shift_feeder #(.WIDTH(8), .DEPTH(4), .AW(2)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clock = ~clock;

   // Downstream shift register sharing clock and reset.
   always @(posedge clock or negedge reset) begin
      if (!reset)        sr <= 8'h00;
      else if (bus.load) sr <= bus.d_in;
      else               sr <= sr >> 1;
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic all_zero(input string tag);
      chk1({tag, "_full"}, bus.full, 1'b0);
      chk3({tag, "_count"}, bus.count, 3'd0);
      chk1({tag, "_ovf"}, bus.overflow, 1'b0);
      chk1({tag, "_busy"}, bus.busy, 1'b0);
      chk1({tag, "_load"}, bus.load, 1'b0);
      chk8({tag, "_din"}, bus.d_in, 8'h00);
   endtask

   // Write sampled at the next edge; returns in the cycle after that edge.
   task automatic wr(input logic [7:0] b);
      bus.wr_en   = 1'b1;
      bus.wr_data = b;
      step();
      bus.wr_en   = 1'b0;
   endtask

   initial begin
      logic [7:0] exp_d;
      bus.wr_en   = 1'b1;
      bus.wr_data = 8'h99;
      bus.flush   = 1'b0;

      // Reset held across three edges with wr_en asserted.
      #2 reset = 1'b0;
      #1 all_zero("rst_async");
      for (int i = 0; i < 3; i++) begin
         step();
         all_zero("rst_hold");
      end
      bus.wr_en = 1'b0;
      #3 reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         chk1("idle_busy", bus.busy, 1'b0);
         chk1("idle_load", bus.load, 1'b0);
         chk3("idle_count", bus.count, 3'd0);
      end

      // Single byte.
      wr(8'h55);
      chk3("single_c0_count", bus.count, 3'd1);
      chk1("single_c0_load", bus.load, 1'b0);
      for (int c = 1; c <= 11; c++) begin
         step();
         chk1("single_load", bus.load, c == 1);
         chk1("single_busy", bus.busy, c <= 9);
         chk8("single_din", bus.d_in, 8'h55);
         if (c == 1) chk3("single_c1_count", bus.count, 3'd0);
      end

      // Back-to-back bytes.
      wr(8'hCC);
      wr(8'hFF);
      chk1("b2b_c1_load", bus.load, 1'b1);
      chk8("b2b_c1_din", bus.d_in, 8'hCC);
      wr(8'h0F);
      chk3("b2b_c2_count", bus.count, 3'd2);
      for (int c = 3; c <= 30; c++) begin
         step();
         chk1("b2b_load", bus.load, (c == 10) || (c == 19));
         chk1("b2b_busy", bus.busy, c <= 27);
         if (c == 10 || c == 19) begin
            exp_d = (c == 10) ? 8'hFF : 8'h0F;
            chk8("b2b_din", bus.d_in, exp_d);
            chk8("b2b_sr_empty", sr, 8'h00);
         end
      end

      // Full and overflow: six writes on consecutive edges.
      wr(8'h11);
      wr(8'h22);
      chk1("ovf_c1_load", bus.load, 1'b1);
      chk8("ovf_c1_din", bus.d_in, 8'h11);
      wr(8'h33);
      wr(8'h44);
      wr(8'h55);
      chk1("ovf_c4_full", bus.full, 1'b1);
      chk1("ovf_c4_ovf", bus.overflow, 1'b0);
      wr(8'h66);
      chk1("ovf_c5_full", bus.full, 1'b1);
      chk3("ovf_c5_count", bus.count, 3'd4);
      chk1("ovf_c5_ovf", bus.overflow, 1'b1);
      for (int c = 6; c <= 50; c++) begin
         step();
         chk1("ovf_load", bus.load, (c == 10) || (c == 19) || (c == 28) || (c == 37));
         chk1("ovf_busy", bus.busy, c <= 45);
         if (bus.load) begin
            case (c)
               10:      exp_d = 8'h22;
               19:      exp_d = 8'h33;
               28:      exp_d = 8'h44;
               default: exp_d = 8'h55;
            endcase
            chk8("ovf_din", bus.d_in, exp_d);
         end
         if (c == 10) begin
            chk1("ovf_c10_full", bus.full, 1'b0);
            chk3("ovf_c10_count", bus.count, 3'd3);
         end
      end

      // Flush during SHIFT with three bytes queued.
      wr(8'hA1);
      wr(8'hA2);
      wr(8'hA3);
      wr(8'hA4);
      chk3("flush_pre_count", bus.count, 3'd3);
      chk1("flush_pre_busy", bus.busy, 1'b1);
      bus.flush = 1'b1;
      step();
      bus.flush = 1'b0;
      chk3("flush_count", bus.count, 3'd0);
      chk1("flush_busy", bus.busy, 1'b0);
      chk1("flush_load", bus.load, 1'b0);
      chk1("flush_full", bus.full, 1'b0);
      chk8("flush_din", bus.d_in, 8'hA1);
      chk1("flush_ovf", bus.overflow, 1'b1);
      for (int c = 0; c < 20; c++) begin
         step();
         chk1("flush_noload", bus.load, 1'b0);
         chk1("flush_nobusy", bus.busy, 1'b0);
      end

      // Asynchronous reset while load is high.
      wr(8'h5A);
      step();
      chk1("arst_pre_load", bus.load, 1'b1);
      #3 reset = 1'b0;
      #1 all_zero("arst_now");
      step();
      all_zero("arst_hold");
      #3 reset = 1'b1;
      wr(8'hA5);
      chk3("arst_c0_count", bus.count, 3'd1);
      chk1("arst_c0_load", bus.load, 1'b0);
      step();
      chk1("arst_c1_load", bus.load, 1'b1);
      chk8("arst_c1_din", bus.d_in, 8'hA5);
      chk1("arst_c1_busy", bus.busy, 1'b1);
      step();
      chk1("arst_c2_load", bus.load, 1'b0);
      chk1("arst_c2_busy", bus.busy, 1'b1);
      chk8("arst_c2_sr", sr, 8'hA5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
